// File: rtl/slow_tick_timer.sv
// Phase-duration timer driven by the divided slow clock. Rising edges of sclk_in
// become one-cycle ticks that count down a loaded duration; a gap monitor flags a stalled divider.
module slow_tick_timer #(
  parameter int DUR_W   = 8,
  parameter int GAP_W   = 27,
  parameter int MAX_GAP = 100100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_in,
  input  logic             start,
  input  logic [DUR_W-1:0] duration,
  input  logic             abort,
  output logic             tick,
  output logic             busy,
  output logic [DUR_W-1:0] remaining,
  output logic             done,
  output logic             tick_lost
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [GAP_W-1:0] MAX_GAP_C = GAP_W'(MAX_GAP);

  state_t             state_q;
  logic               sclk_q;
  logic               tick_q;
  logic               busy_q;
  logic               done_q;
  logic               lost_q;
  logic [DUR_W-1:0]   rem_q;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_d;
  logic               sclk_rise;
  logic               accept;

  assign sclk_rise = sclk_in & ~sclk_q;
  assign accept    = start & ~abort & (state_q == IDLE);

  // Gap counter clears on every rising edge and parks at MAX_GAP instead of wrapping.
  always_comb begin
    gap_d = gap_q;
    if (sclk_rise) begin
      gap_d = '0;
    end else if (gap_q != MAX_GAP_C) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sclk_q  <= sclk_in;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      sclk_q <= sclk_in;
      tick_q <= sclk_rise;
      done_q <= 1'b0;
      gap_q  <= gap_d;

      // A persistent stall re-raises the flag on the cycle after a start clears it.
      if (accept) begin
        lost_q <= 1'b0;
      end else if (gap_d == MAX_GAP_C) begin
        lost_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            if (duration != '0) begin
              rem_q   <= duration;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            rem_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sclk_rise) begin
            if (rem_q > DUR_W'(1)) begin
              rem_q <= rem_q - DUR_W'(1);
            end else begin
              rem_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tick      = tick_q;
  assign busy      = busy_q;
  assign remaining = rem_q;
  assign done      = done_q;
  assign tick_lost = lost_q;

endmodule

// File: tb/tb_slow_tick_timer.sv
// Directed bench for slow_tick_timer: sclk_in is an 8-cycle square wave driven from a phase counter.
module tb_slow_tick_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_in;
  logic       start;
  logic [7:0] duration;
  logic       abort;
  logic       tick;
  logic       busy;
  logic [7:0] remaining;
  logic       done;
  logic       tick_lost;

  int vectors     = 0;
  int miscompares = 0;
  int ph          = 0;
  bit gen         = 1'b0;
  bit hold        = 1'b1;

  slow_tick_timer #(.DUR_W(8), .GAP_W(27), .MAX_GAP(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk_in  (sclk_in),
    .start    (start),
    .duration (duration),
    .abort    (abort),
    .tick     (tick),
    .busy     (busy),
    .remaining(remaining),
    .done     (done),
    .tick_lost(tick_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive sclk_in for this edge (phases 4..7 high), then sample 1 unit after posedge.
  task automatic clk1();
    sclk_in = gen ? (ph >= 4) : hold;
    @(posedge clk);
    #1;
    ph = (ph + 1) % 8;
  endtask

  task automatic next_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      clk1();
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tick_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; sclk_in = 1'b1; start = 1'b0; abort = 1'b0; duration = 8'd0;
    gen = 1'b0; hold = 1'b1;
    clk1();
    clk1();
    chk("rst_tick", 32'(tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rem", 32'(remaining), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_lost", 32'(tick_lost), 0);

    // Release with sclk_in high: three more high cycles, four low, then the true edge.
    rst = 1'b0; gen = 1'b1; ph = 5;
    for (int i = 0; i < 8; i++) begin
      clk1();
      chk($sformatf("release_tick%0d", i), 32'(tick), 32'(i == 7));
    end

    // duration=3 countdown.
    start = 1'b1; duration = 8'd3;
    clk1();
    start = 1'b0;
    chk("d3_busy", 32'(busy), 1);
    chk("d3_rem", 32'(remaining), 3);
    next_tick();
    chk("d3_rem_t1", 32'(remaining), 2);
    chk("d3_done_t1", 32'(done), 0);
    next_tick();
    chk("d3_rem_t2", 32'(remaining), 1);
    chk("d3_busy_t2", 32'(busy), 1);
    next_tick();
    chk("d3_rem_t3", 32'(remaining), 0);
    chk("d3_done_t3", 32'(done), 1);
    chk("d3_busy_t3", 32'(busy), 0);
    clk1();
    chk("d3_done_after", 32'(done), 0);

    // duration=0: immediate done, no countdown.
    start = 1'b1; duration = 8'd0;
    clk1();
    start = 1'b0;
    chk("d0_done", 32'(done), 1);
    chk("d0_busy", 32'(busy), 0);
    chk("d0_rem", 32'(remaining), 0);
    clk1();
    chk("d0_done_after", 32'(done), 0);

    // duration=5, abort on the cycle that samples the third edge.
    start = 1'b1; duration = 8'd5;
    clk1();
    start = 1'b0;
    next_tick();
    next_tick();
    chk("ab_rem_pre", 32'(remaining), 3);
    for (int i = 0; i < 7; i++) clk1();
    abort = 1'b1;
    clk1();
    abort = 1'b0;
    chk("ab_tick", 32'(tick), 1);
    chk("ab_rem", 32'(remaining), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    clk1();
    chk("ab_done_after", 32'(done), 0);

    // start during RUN is ignored.
    start = 1'b1; duration = 8'd4;
    clk1();
    start = 1'b0;
    next_tick();
    chk("rr_rem_t1", 32'(remaining), 3);
    start = 1'b1; duration = 8'd9;
    clk1();
    start = 1'b0;
    chk("rr_rem_ignored", 32'(remaining), 3);
    chk("rr_busy", 32'(busy), 1);
    next_tick();
    chk("rr_rem_t2", 32'(remaining), 2);
    abort = 1'b1;
    clk1();
    abort = 1'b0;
    chk("rr_abort_rem", 32'(remaining), 0);

    // start+abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; duration = 8'd7;
    clk1();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    chk("sa_rem", 32'(remaining), 0);
    chk("sa_done", 32'(done), 0);

    // Stall: sclk_in held low for 25 cycles after an edge.
    next_tick();
    gen = 1'b0; hold = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      clk1();
      chk($sformatf("gap_lost%0d", i), 32'(tick_lost), 32'(i >= 20));
    end
    gen = 1'b1; ph = 0;
    next_tick();
    chk("gap_lost_sticky", 32'(tick_lost), 1);

    // Accepted start clears the flag; rst mid-RUN clears everything.
    start = 1'b1; duration = 8'd2;
    clk1();
    start = 1'b0;
    chk("clr_lost", 32'(tick_lost), 0);
    chk("clr_busy", 32'(busy), 1);
    chk("clr_rem", 32'(remaining), 2);
    next_tick();
    chk("mr_rem_t1", 32'(remaining), 1);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_rem", 32'(remaining), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_tick", 32'(tick), 0);
    for (int i = 0; i < 10; i++) begin
      clk1();
      chk($sformatf("mr_idle_done%0d", i), 32'(done), 0);
    end
    chk("mr_idle_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slow_tick_timer.md
Name: slow_tick_timer

Overview:
- Receiving end of the slow-clock divider output: samples the divided square wave in the fast `clk` domain and converts each rising edge into a one-cycle `tick` enable.
- Uses those ticks to count down a programmable phase duration (density-dependent green/yellow time) for the traffic-light FSM.
- Monitors the divided clock and flags a stalled divider.

Parameters:
- DUR_W, 8, width of duration and remaining count (ticks).
- GAP_W, 27, width of the edge-gap counter.
- MAX_GAP, 100100, clk cycles without a sclk_in rising edge before tick_lost sets. The nominal gap is 100000.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sclk_in  in  1  divided square wave, already in the clk domain (no synchroniser).
- start  in  1  one-cycle request to load duration and begin counting.
- duration  in  DUR_W  phase length in ticks, sampled only on an accepted start.
- abort  in  1  cancels an active countdown.
- tick  out  1  one-cycle pulse per sclk_in rising edge.
- busy  out  1  high while counting.
- remaining  out  DUR_W  ticks left in the current countdown.
- done  out  1  one-cycle pulse when a countdown completes.
- tick_lost  out  1  sticky divider-stall flag.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; tick=0, busy=0, remaining=0, done=0, tick_lost=0; gap counter=0.
  - sclk_d<=sclk_in, so no false edge on reset release.
- Edge detect:
  - edge = sclk_in & ~sclk_d, evaluated at each posedge; sclk_d<=sclk_in every cycle.
  - tick is registered: high for exactly the cycle after the edge is sampled.
  - Falling edges produce nothing.
- States: IDLE, RUN.
- IDLE:
  - start & ~abort with duration!=0: remaining<=duration, busy<=1, go to RUN.
  - start & ~abort with duration==0: done<=1 next cycle, remaining stays 0, busy stays 0, stay IDLE.
  - start & abort in the same cycle: abort wins, start ignored.
- RUN:
  - Priority: abort > edge.
  - abort: remaining<=0, busy<=0, go to IDLE, no done pulse.
  - Edge with remaining>1: remaining<=remaining-1.
  - Edge with remaining==1: remaining<=0, busy<=0, done<=1, go to IDLE.
  - start is ignored; duration is not re-sampled.
- Countdown timing:
  - remaining updates on the same posedge that makes tick high, so tick and the new remaining value appear in the same cycle.
  - done and busy falling are coincident with the final tick.
- Edge counting rule: the edge sampled on the posedge that accepts start does not decrement. The countdown begins with the next edge, so a duration of N always spans N full slow periods minus the partial one in progress.
- done is high for 1 cycle only; all other registered outputs hold between events.
- Gap monitor:
  - Counter increments every cycle, clears to 0 on an edge, and saturates at MAX_GAP.
  - When the counter reaches MAX_GAP, tick_lost<=1.
  - tick_lost stays set until rst or an accepted start. An accepted start clears tick_lost and does not touch the gap counter.
  - The monitor runs in both states; tick_lost does not alter the FSM.
- rst mid-RUN: immediate return to IDLE with all outputs cleared; no done pulse.
- Width: remaining never underflows (0 reachable only via the rules above); gap counter must not wrap.

Test Plan:
All scenarios use MAX_GAP=20 override, DUR_W=8, and sclk_in with period 8 clk (4 high, 4 low) unless noted.
- Reset release with sclk_in=1 -> no tick in the following 3 cycles; first tick one cycle after the next true rising edge; all outputs 0 during reset.
- start with duration=3 -> busy=1 next cycle, remaining=3. Then remaining reads 2, 1, 0 on successive ticks; done pulses exactly once, coincident with the third tick; busy=0 in that same cycle.
- start with duration=0 -> done=1 for one cycle on the next cycle, busy stays 0, no countdown.
- duration=5, abort after 2 ticks -> remaining=0, busy=0 next cycle, no done pulse. Abort asserted in the same cycle as an edge must also win: remaining not decremented first.
- start again during RUN with duration=9 -> ignored, countdown continues from its current remaining; start+abort together in IDLE -> stays IDLE, busy=0.
- Hold sclk_in=0 for 25 cycles -> tick_lost=1 at cycle 20 and stays set after clocking resumes. A later start clears tick_lost; rst mid-RUN clears everything with no done.
